// File: rtl/general_pack.sv
// Shared types and helpers for the Avalon-ST framing blocks.
package general_pack;

  typedef enum logic [1:0] {
    BETWEEN_MSG,
    IN_MSG,
    DROP
  } len_enf_state_t;

  localparam int unsigned MASK_MAX_BYTES = 128;

  // Bit i set means byte i survives; bytes below empty are cleared on an EOP beat.
  function automatic logic [MASK_MAX_BYTES-1:0] empty_byte_mask(input logic [7:0] empty,
                                                                 input logic       eop);
    logic [MASK_MAX_BYTES-1:0] keep;
    keep = '1;
    for (int unsigned i = 0; i < MASK_MAX_BYTES; i++)
      keep[i] = ~eop | (i >= 32'(empty));
    return keep;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle: data, empty, sop, eop, valid, rdy.
interface avalon_st_if #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16
);
  localparam int unsigned EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic [EMPTY_W-1:0]               empty;
  logic                             sop;
  logic                             eop;
  logic                             valid;
  logic                             rdy;

  modport master (output data, empty, sop, eop, valid, input rdy);
  modport slave  (input data, empty, sop, eop, valid, output rdy);
endinterface

// File: rtl/avalon_st_out_reg.sv
// Single-entry registered Avalon-ST stage; o_rdy_up tells the producer a load is possible.
module avalon_st_out_reg #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned EMPTY_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [EMPTY_W-1:0] i_empty,
  input  logic               i_sop,
  input  logic               i_eop,
  input  logic               i_rdy,
  output logic               o_rdy_up,
  output logic               o_valid,
  output logic [DATA_W-1:0]  o_data,
  output logic [EMPTY_W-1:0] o_empty,
  output logic               o_sop,
  output logic               o_eop
);

  assign o_rdy_up = ~o_valid | i_rdy;

  // i_load is only asserted while o_rdy_up is high, so a held beat is never overwritten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_empty <= '0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_empty <= i_empty;
      o_sop   <= i_sop;
      o_eop   <= i_eop;
    end else if (i_rdy) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/avalon_len_enforcer.sv
// Framing repair and maximum-length enforcement for an untrusted Avalon-ST source.
// Define AVALON_LEN_ENFORCER_STATS_EN to add saturating msg/drop/error counters.
module avalon_len_enforcer
  import general_pack::*;
#(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
  parameter int unsigned MAX_MSG_BEATS       = 64,
  parameter int unsigned STAT_CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  avalon_st_if.slave                untrusted_msg,
  avalon_st_if.master               enforced_msg,
  output logic                      missing_sop,
  output logic                      unexpected_sop,
  output logic                      truncated
`ifdef AVALON_LEN_ENFORCER_STATS_EN
  ,
  output logic [STAT_CNT_WIDTH-1:0] msg_cnt,
  output logic [STAT_CNT_WIDTH-1:0] drop_cnt,
  output logic [STAT_CNT_WIDTH-1:0] err_cnt
`endif
);

  localparam int unsigned DATA_W  = 8 * DATA_WIDTH_IN_BYTES;
  localparam int unsigned EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);
  localparam int unsigned CNT_W   = $clog2(MAX_MSG_BEATS + 1);

  if (MAX_MSG_BEATS < 2 || MAX_MSG_BEATS > 65535 || STAT_CNT_WIDTH < 1) begin : g_cfg_invalid
    $error("avalon_len_enforcer: MAX_MSG_BEATS must be 2..65535 and STAT_CNT_WIDTH >= 1");
  end

  len_enf_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_beat_cnt, w_cnt_nxt;
  logic               r_missing_sop, r_unexpected_sop, r_truncated;
  logic               w_rdy_up, w_acc, w_at_limit;
  logic               w_fwd, w_sop, w_eop, w_miss, w_unexp, w_trunc;
  logic [EMPTY_W-1:0] w_empty;
  logic [DATA_WIDTH_IN_BYTES-1:0] w_keep;
  logic [DATA_W-1:0]  w_data;

  assign untrusted_msg.rdy = w_rdy_up;
  assign w_acc      = untrusted_msg.valid & w_rdy_up;
  assign w_at_limit = (r_beat_cnt == CNT_W'(MAX_MSG_BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= BETWEEN_MSG;
      r_beat_cnt       <= '0;
      r_missing_sop    <= 1'b0;
      r_unexpected_sop <= 1'b0;
      r_truncated      <= 1'b0;
    end else begin
      r_missing_sop    <= w_acc & w_miss;
      r_unexpected_sop <= w_acc & w_unexp;
      r_truncated      <= w_acc & w_trunc;
      if (w_acc) begin
        r_state    <= w_state_nxt;
        r_beat_cnt <= w_cnt_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IN_MSG: begin
        if (untrusted_msg.eop)
          w_state_nxt = BETWEEN_MSG;
        else if (untrusted_msg.sop || w_at_limit)
          w_state_nxt = DROP;
      end
      default: begin
        if (untrusted_msg.sop)
          w_state_nxt = untrusted_msg.eop ? BETWEEN_MSG : IN_MSG;
        else if (r_state == DROP && untrusted_msg.eop)
          w_state_nxt = BETWEEN_MSG;
      end
    endcase
  end

  always_comb begin
    w_fwd     = 1'b0;
    w_sop     = 1'b0;
    w_eop     = untrusted_msg.eop;
    w_empty   = untrusted_msg.eop ? untrusted_msg.empty : '0;
    w_miss    = 1'b0;
    w_unexp   = 1'b0;
    w_trunc   = 1'b0;
    w_cnt_nxt = r_beat_cnt;
    case (r_state)
      IN_MSG: begin
        w_fwd     = 1'b1;
        w_cnt_nxt = r_beat_cnt + CNT_W'(1);
        w_unexp   = untrusted_msg.sop;
        w_trunc   = w_at_limit & ~untrusted_msg.eop;
        if (w_unexp || w_trunc) begin
          w_eop   = 1'b1;
          w_empty = '0;
        end
      end
      default: begin
        if (untrusted_msg.sop) begin
          w_fwd     = 1'b1;
          w_sop     = 1'b1;
          w_cnt_nxt = CNT_W'(1);
        end else begin
          w_miss = (r_state == BETWEEN_MSG);
        end
      end
    endcase
  end

  always_comb begin
    w_keep = DATA_WIDTH_IN_BYTES'(empty_byte_mask(8'(w_empty), w_eop));
    w_data = '0;
    for (int unsigned b = 0; b < DATA_WIDTH_IN_BYTES; b++)
      w_data[8*b +: 8] = w_keep[b] ? untrusted_msg.data[8*b +: 8] : 8'h00;
  end

  avalon_st_out_reg #(
    .DATA_W  (DATA_W),
    .EMPTY_W (EMPTY_W)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_acc & w_fwd),
    .i_data   (w_data),
    .i_empty  (w_empty),
    .i_sop    (w_sop),
    .i_eop    (w_eop),
    .i_rdy    (enforced_msg.rdy),
    .o_rdy_up (w_rdy_up),
    .o_valid  (enforced_msg.valid),
    .o_data   (enforced_msg.data),
    .o_empty  (enforced_msg.empty),
    .o_sop    (enforced_msg.sop),
    .o_eop    (enforced_msg.eop)
  );

  assign missing_sop    = r_missing_sop;
  assign unexpected_sop = r_unexpected_sop;
  assign truncated      = r_truncated;

`ifdef AVALON_LEN_ENFORCER_STATS_EN
  logic [STAT_CNT_WIDTH-1:0] r_msg_cnt, r_drop_cnt, r_err_cnt;
  logic [STAT_CNT_WIDTH:0]   w_err_sum;

  // Wide sum so a +2 step near the top still saturates instead of wrapping.
  assign w_err_sum = {1'b0, r_err_cnt} + (STAT_CNT_WIDTH+1)'(w_acc & w_miss)
                   + (STAT_CNT_WIDTH+1)'(w_acc & w_unexp) + (STAT_CNT_WIDTH+1)'(w_acc & w_trunc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_msg_cnt  <= '0;
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_acc && w_fwd && w_eop && r_msg_cnt != '1)
        r_msg_cnt <= r_msg_cnt + STAT_CNT_WIDTH'(1);
      if (w_acc && !w_fwd && r_drop_cnt != '1)
        r_drop_cnt <= r_drop_cnt + STAT_CNT_WIDTH'(1);
      r_err_cnt <= w_err_sum[STAT_CNT_WIDTH] ? '1 : w_err_sum[STAT_CNT_WIDTH-1:0];
    end
  end

  assign msg_cnt  = r_msg_cnt;
  assign drop_cnt = r_drop_cnt;
  assign err_cnt  = r_err_cnt;
`endif

endmodule

// File: tb/tb_avalon_len_enforcer.sv
// Directed scoreboard bench for avalon_len_enforcer with MAX_MSG_BEATS=4, 16-byte beats.
module tb_avalon_len_enforcer;

  localparam int unsigned DWB  = 16;
  localparam int unsigned MAXB = 4;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   empty;
    logic         sop;
    logic         eop;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) src();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) snk();
  logic missing_sop, unexpected_sop, truncated;
`ifdef AVALON_LEN_ENFORCER_STATS_EN
  logic [15:0] msg_cnt, drop_cnt, err_cnt;
`endif

  avalon_len_enforcer #(
    .DATA_WIDTH_IN_BYTES (DWB),
    .MAX_MSG_BEATS       (MAXB),
    .STAT_CNT_WIDTH      (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .untrusted_msg  (src),
    .enforced_msg   (snk),
    .missing_sop    (missing_sop),
    .unexpected_sop (unexpected_sop),
    .truncated      (truncated)
`ifdef AVALON_LEN_ENFORCER_STATS_EN
    ,
    .msg_cnt        (msg_cnt),
    .drop_cnt       (drop_cnt),
    .err_cnt        (err_cnt)
`endif
  );

  beat_t q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cnt_miss = 0, cnt_unexp = 0, cnt_trunc = 0;
  int exp_miss = 0, exp_unexp = 0, exp_trunc = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] keep_bytes(input logic [127:0] d, input int unsigned emp,
                                              input logic eop);
    logic [127:0] r;
    r = d;
    if (eop)
      for (int unsigned i = 0; i < emp; i++) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(negedge clk) begin
    if (missing_sop)    cnt_miss++;
    if (unexpected_sop) cnt_unexp++;
    if (truncated)      cnt_trunc++;
    if (rst && snk.valid && snk.rdy) begin
      if (q.size() == 0) begin
        check("spurious_output_beat", 128'(q.size()), 128'd1);
      end else begin
        beat_t e;
        e = q.pop_front();
        check("out_data",  snk.data,  e.data);
        check("out_empty", 128'(snk.empty), 128'(e.empty));
        check("out_sop",   128'(snk.sop),   128'(e.sop));
        check("out_eop",   128'(snk.eop),   128'(e.eop));
      end
    end
  end

  // Drive one input beat; fwd/osop/oeop/oemp describe what the sink must see.
  task automatic send(input logic [127:0] d, input int unsigned emp, input logic sop,
                      input logic eop, input logic fwd, input logic osop, input logic oeop,
                      input int unsigned oemp);
    int unsigned waited;
    beat_t e;
    waited = 0;
    src.data  = d;
    src.empty = 4'(emp);
    src.sop   = sop;
    src.eop   = eop;
    src.valid = 1'b1;
    @(negedge clk);
    while (!src.rdy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!src.rdy) begin
      check("accept_timeout", 128'(src.rdy), 128'd1);
      src.valid = 1'b0;
      return;
    end
    if (fwd) begin
      e.data  = keep_bytes(d, oemp, oeop);
      e.empty = 4'(oemp);
      e.sop   = osop;
      e.eop   = oeop;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (fwd) check("one_cycle_latency", 128'(snk.valid), 128'd1);
  endtask

  task automatic fwd_beat(input logic [127:0] d, input int unsigned emp, input logic sop,
                          input logic eop);
    send(d, emp, sop, eop, 1'b1, sop, eop, eop ? emp : 0);
  endtask

  task automatic drop_beat(input logic [127:0] d, input int unsigned emp, input logic sop,
                           input logic eop);
    send(d, emp, sop, eop, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic settle_and_check(input string tag);
    src.valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_missing_sop"},    128'(cnt_miss),  128'(exp_miss));
    check({tag, "_unexpected_sop"}, 128'(cnt_unexp), 128'(exp_unexp));
    check({tag, "_truncated"},      128'(cnt_trunc), 128'(exp_trunc));
    check({tag, "_drained"},        128'(q.size()),  128'd0);
  endtask

  logic [127:0] d1, d2;

  initial begin
    src.valid = 1'b0;
    src.data  = '0;
    src.empty = '0;
    src.sop   = 1'b0;
    src.eop   = 1'b0;
    snk.rdy   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 128'(snk.valid), 128'd0);
    check("reset_data",  snk.data, 128'd0);
    check("reset_pulses", 128'({missing_sop, unexpected_sop, truncated}), 128'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Clean 3-beat message, last beat with empty=5.
    fwd_beat(rnd128(), 0, 1'b1, 1'b0);
    fwd_beat(rnd128(), 0, 1'b0, 1'b0);
    fwd_beat(rnd128(), 5, 1'b0, 1'b1);
    settle_and_check("clean");

    // Stray non-SOP beat, then a normal message.
    drop_beat(rnd128(), 0, 1'b0, 1'b0);
    exp_miss++;
    fwd_beat(rnd128(), 0, 1'b1, 1'b0);
    fwd_beat(rnd128(), 3, 1'b0, 1'b1);
    settle_and_check("missing_sop");

    // SOP inside an open message closes it; rest dropped up to EOP.
    fwd_beat(rnd128(), 0, 1'b1, 1'b0);
    send(rnd128(), 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    exp_unexp++;
    drop_beat(rnd128(), 0, 1'b0, 1'b0);
    drop_beat(rnd128(), 2, 1'b0, 1'b1);
    settle_and_check("unexpected_sop");

    // 6-beat message cut at 4, then a single-beat message.
    fwd_beat(rnd128(), 0, 1'b1, 1'b0);
    fwd_beat(rnd128(), 0, 1'b0, 1'b0);
    fwd_beat(rnd128(), 0, 1'b0, 1'b0);
    send(rnd128(), 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    exp_trunc++;
    drop_beat(rnd128(), 0, 1'b0, 1'b0);
    drop_beat(rnd128(), 0, 1'b0, 1'b1);
    fwd_beat(rnd128(), 2, 1'b1, 1'b1);
    settle_and_check("truncate");

    // Genuine EOP exactly on beat MAX_MSG_BEATS: no truncation.
    fwd_beat(rnd128(), 0, 1'b1, 1'b0);
    fwd_beat(rnd128(), 0, 1'b0, 1'b0);
    fwd_beat(rnd128(), 0, 1'b0, 1'b0);
    fwd_beat(rnd128(), 1, 1'b0, 1'b1);
    settle_and_check("exact_max");

    // SOP on the limit beat raises both pulses; SOP in DROP starts cleanly.
    fwd_beat(rnd128(), 0, 1'b1, 1'b0);
    fwd_beat(rnd128(), 0, 1'b0, 1'b0);
    fwd_beat(rnd128(), 0, 1'b0, 1'b0);
    send(rnd128(), 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    exp_unexp++;
    exp_trunc++;
    fwd_beat(rnd128(), 2, 1'b1, 1'b1);
    settle_and_check("sop_at_limit");

    // SOP+EOP inside a message returns to BETWEEN_MSG, so a stray beat is missing_sop.
    fwd_beat(rnd128(), 0, 1'b1, 1'b0);
    send(rnd128(), 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    exp_unexp++;
    drop_beat(rnd128(), 0, 1'b0, 1'b0);
    exp_miss++;
    settle_and_check("sop_eop_inside");

    // Back-pressure for 5 cycles mid-message.
    snk.rdy = 1'b0;
    d1 = rnd128();
    d2 = rnd128();
    fwd_beat(d1, 0, 1'b1, 1'b0);
    src.data  = d2;
    src.empty = '0;
    src.sop   = 1'b0;
    src.eop   = 1'b0;
    src.valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_src_rdy_low", 128'(src.rdy), 128'd0);
      check("bp_hold_data",   snk.data, d1);
      check("bp_hold_sop",    128'({snk.valid, snk.sop, snk.eop}), 128'b110);
      @(posedge clk);
      #1;
    end
    q.push_back('{d2, 4'd0, 1'b0, 1'b0});
    snk.rdy = 1'b1;
    @(negedge clk);
    check("bp_release_rdy", 128'(src.rdy), 128'd1);
    @(posedge clk);
    #1;
    check("bp_next_beat_loaded", snk.data, d2);
    fwd_beat(rnd128(), 6, 1'b0, 1'b1);
    settle_and_check("backpressure");

    // Reset while beat 2 is held in the output register.
    fwd_beat(rnd128(), 0, 1'b1, 1'b0);
    fwd_beat(rnd128(), 0, 1'b0, 1'b0);
    snk.rdy   = 1'b0;
    src.valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("rst_valid", 128'(snk.valid), 128'd0);
    check("rst_data",  snk.data, 128'd0);
    check("rst_ctrl",  128'({snk.sop, snk.eop, snk.empty}), 128'd0);
    check("rst_pulses", 128'({missing_sop, unexpected_sop, truncated}), 128'd0);
`ifdef AVALON_LEN_ENFORCER_STATS_EN
    check("rst_stats", {80'd0, msg_cnt, drop_cnt, err_cnt}, 128'd0);
`endif
    q.delete();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    snk.rdy = 1'b1;
    drop_beat(rnd128(), 0, 1'b0, 1'b0);
    exp_miss++;
    fwd_beat(rnd128(), 0, 1'b1, 1'b1);
    settle_and_check("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/avalon_len_enforcer.md
Name: avalon_len_enforcer

Overview:
- Successor to the single-channel SOP/EOP enforcer.
- Sits between an untrusted Avalon-ST source and a trusted sink.
- Repairs framing (missing SOP, unexpected SOP) and enforces a parametrised maximum message length by forcing EOP and dropping the remainder.
- Zeroes invalid bytes on EOP beats, presents a registered output with full rdy back-pressure, and reports error pulses.

Parameters:
- DATA_WIDTH_IN_BYTES, 16: beat width in bytes; empty is $clog2(DATA_WIDTH_IN_BYTES) bits.
- MAX_MSG_BEATS, 64: maximum beats per message; legal range 2..65535.
- STAT_CNT_WIDTH, 16: width of statistics counters (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- untrusted_msg  avalon_st_if.slave  -  input stream (data, empty, sop, eop, valid, rdy)
- enforced_msg  avalon_st_if.master  -  output stream
- missing_sop  output  1  one-cycle pulse: non-SOP beat accepted outside a message, dropped
- unexpected_sop  output  1  one-cycle pulse: SOP beat accepted inside a message
- truncated  output  1  one-cycle pulse: message cut at MAX_MSG_BEATS

Behaviour:
- Reset is asynchronous on rst low: state=BETWEEN_MSG, beat_cnt=0, enforced_msg.valid/sop/eop/empty/data=0, all pulse outputs=0. Reset mid-message discards the held beat; the next accepted beat must carry SOP.
- Accept condition: untrusted_msg.valid & untrusted_msg.rdy. State, counters and pulses update only on accepted beats.
- Handshake:
  - untrusted_msg.rdy = ~enforced_msg.valid | enforced_msg.rdy (combinational).
  - enforced_msg holds data, empty, sop and eop stable while valid & ~rdy.
  - Latency is 1 cycle. Back-to-back throughput is 1 beat/cycle.
- Forwarded beats load the output register. Dropped beats are accepted but never shown on the output.
- State BETWEEN_MSG:
  - sop beat: forwarded with sop=1, beat_cnt=1. If eop=1, stay; else go to IN_MSG.
  - non-sop beat: dropped, missing_sop pulses, stay.
- State IN_MSG:
  - Normal beat: forwarded with sop=0, beat_cnt increments. eop=1 goes to BETWEEN_MSG.
  - sop=1 beat: forwarded with sop cleared, eop forced to 1, empty=0. unexpected_sop pulses. If the input also had eop=1, go to BETWEEN_MSG; else go to DROP. This closes the open message.
  - Length limit: a beat arriving with beat_cnt==MAX_MSG_BEATS-1 and eop=0 is forwarded with eop forced to 1, empty=0. truncated pulses and the state goes to DROP. With eop=1 at that count, the beat is a normal end (no pulse).
  - sop and length limit on the same beat: both unexpected_sop and truncated pulse; the next state is DROP.
- State DROP:
  - sop beat: treated exactly as in BETWEEN_MSG (new message starts, no error pulse).
  - non-sop beat: dropped, no pulse. If eop=1, go to BETWEEN_MSG.
- Empty and data on forwarded beats:
  - empty on output equals input empty only on genuine input-eop beats; otherwise 0.
  - Byte i of data is zeroed when output eop=1 and empty>i; otherwise data passes unchanged.
- Pulse outputs are registered and assert the cycle after the accepting edge, for exactly one cycle.

Optional Feature:
- Macro: AVALON_LEN_ENFORCER_STATS_EN.
- When defined, adds three outputs, each STAT_CNT_WIDTH wide:
  - msg_cnt: counts forwarded EOP beats.
  - drop_cnt: counts dropped beats.
  - err_cnt: counts missing_sop, unexpected_sop and truncated events; two on the same beat count +2.
- All counters saturate at all-ones and reset to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- general_pack gains:
  - enum len_enf_state_t {BETWEEN_MSG, IN_MSG, DROP}.
  - function empty_byte_mask(empty, eop) returning the per-byte keep mask.
- Beat counter width is local: $clog2(MAX_MSG_BEATS+1).
- One sub-module, avalon_st_out_reg: a single-entry registered Avalon-ST stage producing rdy upstream. It is reusable elsewhere.

Test Plan:
- Clean stream, MAX_MSG_BEATS=4: 3-beat message (sop, mid, eop with empty=5) -> identical beats out 1 cycle later; bytes 0..4 of the last beat are zero; no pulses.
- Beat with valid=1, sop=0 in BETWEEN_MSG, then a normal message -> the first beat is dropped, missing_sop pulses once, and the message passes intact.
- sop on beat 2 of an open message, followed by 2 beats ending in eop:
  - the sop beat is output with sop=0, eop=1, empty=0;
  - unexpected_sop pulses once;
  - the next 2 beats are dropped.
- MAX_MSG_BEATS=4, 6-beat message -> 4 beats out with eop forced on beat 4, truncated pulses, beats 5-6 dropped, and the next sop message passes.
- Back-pressure: enforced_msg.rdy held low 5 cycles mid-message -> output stable, untrusted_msg.rdy low, no loss or duplication on release.
- rst asserted while beat 2 is held -> outputs 0 immediately; after release, a non-sop beat gives missing_sop; with STATS_EN, counters read 0 after reset.
